// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory loader.
//   state_t    : loader FSM state encodings
//   LEN_W      : width of the word-count header and word index
//   WORD_BYTES : bytes per instruction word
//   csum_next  : running XOR checksum helper
package imem_loader_pkg;

  localparam int LEN_W      = 16;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // Running checksum over data bytes is a plain XOR.
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: packs a little-endian byte stream into 32-bit words.
//   clk        : clock
//   rst_n      : synchronous active-low reset
//   clear      : synchronous clear, discards any partial word
//   byte_en    : accept byte_in this cycle
//   byte_in    : stream byte
//   lane       : index of the next byte within the current word
//   word_valid : registered one-cycle pulse, the cycle after the 4th byte
//   word       : registered packed word {b3,b2,b1,b0}
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  lane,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane_r;
  logic [23:0] shift_r;
  logic        word_valid_r;
  logic [31:0] word_r;

  // Byte lane counter and shift register; completes a word on the last lane.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      lane_r       <= 2'd0;
      shift_r      <= 24'd0;
      word_valid_r <= 1'b0;
      word_r       <= 32'd0;
    end else begin
      word_valid_r <= 1'b0;
      if (byte_en) begin
        if (lane_r == 2'(WORD_BYTES - 1)) begin
          // Newest byte is the most significant: little-endian packing.
          word_r       <= {byte_in, shift_r};
          word_valid_r <= 1'b1;
          lane_r       <= 2'd0;
          shift_r      <= 24'd0;
        end else begin
          shift_r <= {byte_in, shift_r[23:8]};
          lane_r  <= lane_r + 2'd1;
        end
      end
    end
  end

  assign lane       = lane_r;
  assign word_valid = word_valid_r;
  assign word       = word_r;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a program image as a byte stream (LEN_LO, LEN_HI,
// 4*N data bytes, optional CSUM) and writes it into instruction memory as
// little-endian 32-bit words while holding the CPU.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the trailing CSUM byte,
// XOR of all data bytes; mismatch ends in err).
// Ports:
//   CLK, Reset_L          : clock, synchronous active-low reset
//   start                 : pulse, starts a session from IDLE/DONE/ERR
//   byte_in, byte_valid   : stream byte and its valid
//   byte_ready            : loader accepts a byte (transfer = valid & ready)
//   wr_en, wr_addr, wr_data : instruction-memory write port
//   cpu_hold, busy        : high while a session is in progress
//   done, err             : sticky session outcome flags, cleared by start
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          MEM_WORDS = 64,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [63:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [LEN_W:0] MAX_N = (LEN_W + 1)'(MEM_WORDS);

  state_t           state_r;
  logic             byte_ready_r;
  logic             cpu_hold_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic             drain_r;
  logic [7:0]       len_lo_r;
  logic [LEN_W-1:0] n_r;
  logic [LEN_W-1:0] widx_r;
  logic [7:0]       csum_r;
  logic [63:0]      wr_addr_r;

  logic             start_go_s;
  logic             xfer_s;
  logic [LEN_W-1:0] n_s;
  logic             data_xfer_s;
  logic             word_end_s;
  logic             last_s;
  logic [1:0]       lane_s;

  assign start_go_s  = start & ((state_r == ST_IDLE) | (state_r == ST_DONE) | (state_r == ST_ERR));
  assign xfer_s      = byte_valid & byte_ready_r;
  assign n_s         = {byte_in, len_lo_r};
  assign data_xfer_s = xfer_s & (state_r == ST_DATA) & ~drain_r;
  assign word_end_s  = data_xfer_s & (lane_s == 2'(WORD_BYTES - 1));
  assign last_s      = word_end_s & (widx_r == (n_r - LEN_W'(1)));

  imem_word_packer u_packer (
    .clk        (CLK),
    .rst_n      (Reset_L),
    .clear      (start_go_s),
    .byte_en    (data_xfer_s),
    .byte_in    (byte_in),
    .lane       (lane_s),
    .word_valid (wr_en),
    .word       (wr_data)
  );

  // Session FSM with registered handshake, status and write-address outputs.
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_r      <= ST_IDLE;
      byte_ready_r <= 1'b0;
      cpu_hold_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      drain_r      <= 1'b0;
      len_lo_r     <= 8'd0;
      n_r          <= '0;
      widx_r       <= '0;
      csum_r       <= 8'd0;
      wr_addr_r    <= 64'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_go_s) begin
            state_r      <= ST_LEN_LO;
            byte_ready_r <= 1'b1;
            cpu_hold_r   <= 1'b1;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            drain_r      <= 1'b0;
            widx_r       <= '0;
            csum_r       <= 8'd0;
          end
        end
        ST_LEN_LO: begin
          if (xfer_s) begin
            len_lo_r <= byte_in;
            state_r  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (xfer_s) begin
            n_r <= n_s;
            if ({1'b0, n_s} > MAX_N) begin
              state_r      <= ST_ERR;
              err_r        <= 1'b1;
              byte_ready_r <= 1'b0;
              cpu_hold_r   <= 1'b0;
              busy_r       <= 1'b0;
            end else if (n_s == LEN_W'(0)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_r <= ST_CSUM;
`else
              state_r      <= ST_DONE;
              done_r       <= 1'b1;
              byte_ready_r <= 1'b0;
              cpu_hold_r   <= 1'b0;
              busy_r       <= 1'b0;
`endif
            end else begin
              state_r <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (drain_r) begin
            // Final write cycle has just been presented; finish now.
            state_r    <= ST_DONE;
            done_r     <= 1'b1;
            drain_r    <= 1'b0;
            cpu_hold_r <= 1'b0;
            busy_r     <= 1'b0;
          end else if (data_xfer_s) begin
            csum_r <= csum_next(csum_r, byte_in);
            if (word_end_s) begin
              wr_addr_r <= BASE_ADDR + {{(64 - LEN_W - 2){1'b0}}, widx_r, 2'b00};
              widx_r    <= widx_r + LEN_W'(1);
            end
            if (last_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_r <= ST_CSUM;
`else
              drain_r      <= 1'b1;
              byte_ready_r <= 1'b0;
`endif
            end
          end
        end
        ST_CSUM: begin
          if (xfer_s) begin
            byte_ready_r <= 1'b0;
            cpu_hold_r   <= 1'b0;
            busy_r       <= 1'b0;
            if (byte_in == csum_r) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_ERR;
              err_r   <= 1'b1;
            end
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          byte_ready_r <= 1'b0;
          cpu_hold_r   <= 1'b0;
          busy_r       <= 1'b0;
          drain_r      <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_r;
  assign wr_addr    = wr_addr_r;
  assign cpu_hold   = cpu_hold_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for imem_loader. Stimulus pushes
// expected writes into a queue; a negedge monitor pops and compares on wr_en.
module tb_imem_loader;

  logic        CLK;
  logic        Reset_L;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.MEM_WORDS(64), .BASE_ADDR(64'h0)) dut (
    .CLK        (CLK),
    .Reset_L    (Reset_L),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          wr_cyc[$];
  logic [31:0] prog_q[$];
  int          errors = 0;
  int          checks = 0;
  int          wr_count = 0;
  int          cyc = 0;
  logic [7:0]  tb_csum;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge CLK) begin
    if (wr_en === 1'b1) begin
      wr_count++;
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", {32'd0, wr_data}, {32'd0, e.data});
      end
      check("hold_during_write", {63'd0, cpu_hold}, 64'd1);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (byte_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout: got ready=%0b expected 1", byte_ready);
    end
    @(negedge CLK);
    byte_valid = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("hold_after_start", {63'd0, cpu_hold}, 64'd1);
  endtask

  task automatic send_header(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  // Sends prog_q as data, queuing the expected write for each word.
  task automatic send_data();
    tb_csum = 8'd0;
    for (int i = 0; i < prog_q.size(); i++) begin
      wr_t e;
      logic [31:0] w;
      w = prog_q[i];
      e.addr = 64'(i) * 64'd4;
      e.data = w;
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8]);
        tb_csum = tb_csum ^ w[8*k +: 8];
      end
    end
  endtask

  task automatic wait_idle(input string name);
    for (int t = 0; t < 40 && busy === 1'b1; t++) @(negedge CLK);
    check({name, "_busy_low"}, {63'd0, busy}, 64'd0);
    @(negedge CLK);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic full_session(input string name);
    start_pulse();
    send_header(16'(prog_q.size()));
    send_data();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(tb_csum);
`endif
    wait_idle(name);
  endtask

  initial begin
    int base;
    Reset_L    = 1'b0;
    start      = 1'b0;
    byte_in    = 8'd0;
    byte_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hold", {63'd0, cpu_hold}, 64'd0);
    check("rst_done_err", {62'd0, done, err}, 64'd0);
    check("rst_ready", {63'd0, byte_ready}, 64'd0);
    check("rst_wr_addr", wr_addr, 64'd0);
    Reset_L = 1'b1;
    @(negedge CLK);

    // 1: single word, bytes 01 00 E9 03 40 F8 [52]
    base = wr_count;
    prog_q = '{32'hF84003E9};
    full_session("t1");
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t1_csum_value", {56'd0, tb_csum}, 64'h52);
`endif
    check("t1_writes", 64'(wr_count - base), 64'd1);
    check("t1_done", {62'd0, done, err}, 64'd2);

    // 2: 13-word program, back-to-back bytes, no bubble between writes
    base = wr_count;
    wr_cyc.delete();
    prog_q = '{32'hF84003E9, 32'hF84103EA, 32'h8B020021, 32'hD1000421, 32'hF84103EB,
               32'hAA0103E2, 32'h91000842, 32'hF84203EC, 32'hCB020020, 32'h8A010002,
               32'hB100041F, 32'h54FFFFE1, 32'hF84203ED};
    full_session("t2");
    check("t2_writes", 64'(wr_count - base), 64'd13);
    if (wr_cyc.size() == 13)
      check("t2_no_bubble", 64'(wr_cyc[12] - wr_cyc[0]), 64'd48);
    else
      check("t2_write_cycles", 64'(wr_cyc.size()), 64'd13);
    check("t2_done", {62'd0, done, err}, 64'd2);

    // 3: N=65 exceeds capacity -> err after LEN_HI, no writes
    base = wr_count;
    start_pulse();
    send_header(16'd65);
    check("t3_err", {62'd0, done, err}, 64'd1);
    check("t3_hold", {63'd0, cpu_hold}, 64'd0);
    check("t3_ready", {63'd0, byte_ready}, 64'd0);
    repeat (3) @(negedge CLK);
    check("t3_writes", 64'(wr_count - base), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 4: wrong checksum -> write still issued, err set
    base = wr_count;
    prog_q = '{32'hF84003E9};
    start_pulse();
    send_header(16'd1);
    send_data();
    send_byte(8'h00);
    wait_idle("t4");
    check("t4_writes", 64'(wr_count - base), 64'd1);
    check("t4_err", {62'd0, done, err}, 64'd1);
`endif

    // 5: reset mid-word, then a fresh single-word load
    base = wr_count;
    start_pulse();
    send_header(16'd1);
    send_byte(8'hE9);
    send_byte(8'h03);
    Reset_L = 1'b0;
    @(negedge CLK);
    Reset_L = 1'b1;
    check("t5_rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("t5_rst_hold", {63'd0, cpu_hold}, 64'd0);
    check("t5_rst_busy", {63'd0, busy}, 64'd0);
    @(negedge CLK);
    check("t5_no_stale_write", 64'(wr_count - base), 64'd0);
    prog_q = '{32'hDDCCBBAA};
    full_session("t5");
    check("t5_writes", 64'(wr_count - base), 64'd1);
    check("t5_done", {62'd0, done, err}, 64'd2);

    // 6: N=0 with a start pulse while busy that must be ignored
    base = wr_count;
    start_pulse();
    send_byte(8'h00);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    wait_idle("t6");
    check("t6_done", {62'd0, done, err}, 64'd2);
    check("t6_writes", 64'(wr_count - base), 64'd0);

    // 7: N == MEM_WORDS is legal; last word at 0xFC
    base = wr_count;
    prog_q.delete();
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b0;
      b0 = 8'(4 * i);
      prog_q.push_back({b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
    end
    full_session("t7");
    check("t7_writes", 64'(wr_count - base), 64'd64);
    check("t7_done", {62'd0, done, err}, 64'd2);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
